// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed image over 8N1 serial,
// writes it word by word into program RAM, then releases the core.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_we_o,
  output logic        busy_o,
  output logic        core_run_o,
  output logic        err_o
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] MAX_N     = 32'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {LD_LEN, LD_WORD, LD_CSUM, LD_DONE, LD_ERROR} ld_state_e;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_vld_q, byte_vld_d, frame_err_q, frame_err_d;

  ld_state_e   ld_state_q, ld_state_d;
  logic [1:0]  ld_cnt_q, ld_cnt_d;
  logic [31:0] asm_q, asm_d, asm_next;
  logic [31:0] len_q, len_d, widx_q, widx_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        we_q, we_d, busy_q, busy_d, run_q, run_d, err_q, err_d;

  // Two-flop RX synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX bit-timing state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      clk_cnt_q   <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  // RX next state: mid-bit sampling, start-bit glitch reject, stop-bit check
  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = 16'd0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
        else                       rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
          bit_cnt_d = 3'd0;
          if (!rx_s2_q) rx_state_d = RX_DATA;
          else          rx_state_d = RX_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_cnt_d  = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = 16'd0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) byte_vld_d  = 1'b1;
          else         frame_err_d = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Loader state register and registered RAM/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q <= LD_LEN;
      ld_cnt_q   <= 2'd0;
      asm_q      <= 32'd0;
      len_q      <= 32'd0;
      widx_q     <= 32'd0;
      xor_q      <= 8'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      ld_cnt_q   <= ld_cnt_d;
      asm_q      <= asm_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      xor_q      <= xor_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  assign asm_next = {shift_q, asm_q[31:8]};

  // Loader next state: bytes shift in from the top so byte k lands at bits 8k+7:8k
  always_comb begin
    ld_state_d = ld_state_q;
    ld_cnt_d   = ld_cnt_q;
    asm_d      = asm_q;
    len_d      = len_q;
    widx_d     = widx_q;
    xor_d      = xor_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    run_d      = run_q;
    err_d      = err_q;
    case (ld_state_q)
      LD_LEN, LD_WORD, LD_CSUM: begin
        if (frame_err_q) begin
          ld_state_d = LD_ERROR;
          err_d      = 1'b1;
        end else if (byte_vld_q) begin
          if (ld_state_q == LD_CSUM) begin
            if (shift_q == xor_q) begin
              ld_state_d = LD_DONE;
              run_d      = 1'b1;
            end else begin
              ld_state_d = LD_ERROR;
              err_d      = 1'b1;
            end
          end else begin
            asm_d    = asm_next;
            ld_cnt_d = ld_cnt_q + 2'd1;
            if (ld_state_q == LD_LEN) begin
              if (ld_cnt_q == 2'd3) begin
                len_d  = asm_next;
                widx_d = 32'd0;
                xor_d  = 8'd0;
                if (asm_next > MAX_N) begin
                  ld_state_d = LD_ERROR;
                  err_d      = 1'b1;
                end else if (asm_next == 32'd0) begin
                  ld_state_d = LD_CSUM;
                end else begin
                  ld_state_d = LD_WORD;
                end
              end else begin
                ld_state_d = LD_LEN;
              end
            end else begin
              xor_d = csum_step(xor_q, shift_q);
              if (ld_cnt_q == 2'd3) begin
                we_d   = 1'b1;
                addr_d = widx_q;
                data_d = asm_next;
                widx_d = widx_q + 32'd1;
                if (widx_q + 32'd1 == len_q) ld_state_d = LD_CSUM;
                else                         ld_state_d = LD_WORD;
              end else begin
                ld_state_d = LD_WORD;
              end
            end
          end
        end else begin
          ld_state_d = ld_state_q;
        end
      end
      LD_DONE:  ld_state_d = LD_DONE;
      LD_ERROR: ld_state_d = LD_ERROR;
      default: begin
        ld_state_d = LD_ERROR;
        err_d      = 1'b1;
      end
    endcase
    busy_d = ((ld_state_d == LD_LEN) && (ld_cnt_d != 2'd0)) ||
             (ld_state_d == LD_WORD) || (ld_state_d == LD_CSUM);
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign mem_we_o   = we_q;
  assign busy_o     = busy_q;
  assign core_run_o = run_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: serialises 8N1 frames and checks RAM writes and status.
module tb_uart_boot_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] mem_addr, mem_data;
  logic        mem_we, busy, core_run, err;

  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          base;
  logic [31:0] wr_addr [256];
  logic [31:0] wr_data [256];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_we_o(mem_we),
    .busy_o(busy), .core_run_o(core_run), .err_o(err)
  );

  always #5 clk = ~clk;

  // Log every cycle the write strobe is high (a stretched pulse shows up as extra writes)
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr[wr_cnt[7:0]] <= mem_addr;
      wr_data[wr_cnt[7:0]] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_s1(input logic [7:0] csum);
    logic [7:0] f [12];
    f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 12; i++) send_byte(f[i], 1'b1);
    send_byte(csum, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_we",   {31'd0, mem_we},   32'd0);
    check_eq("rst_addr", mem_addr,          32'd0);
    check_eq("rst_data", mem_data,          32'd0);
    check_eq("rst_busy", {31'd0, busy},     32'd0);
    check_eq("rst_run",  {31'd0, core_run}, 32'd0);
    check_eq("rst_err",  {31'd0, err},      32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Scenario 1: two-word image, good checksum
    base = wr_cnt;
    send_byte(8'h02, 1'b1);
    check_eq("s1_busy_mid", {31'd0, busy}, 32'd1);
    check_eq("s1_run_mid",  {31'd0, core_run}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    send_byte(8'h2A, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("s1_nwr",   32'(wr_cnt - base), 32'd2);
    check_eq("s1_a0",    wr_addr[base[7:0]], 32'd0);
    check_eq("s1_d0",    wr_data[base[7:0]], 32'h12345678);
    check_eq("s1_a1",    wr_addr[8'(base + 1)], 32'd1);
    check_eq("s1_d1",    wr_data[8'(base + 1)], 32'hDEADBEEF);
    check_eq("s1_run",   {31'd0, core_run}, 32'd1);
    check_eq("s1_err",   {31'd0, err},      32'd0);
    check_eq("s1_busy",  {31'd0, busy},     32'd0);
    check_eq("s1_hold_a", mem_addr, 32'd1);
    check_eq("s1_hold_d", mem_data, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) send_byte(8'h01, 1'b1);
    check_eq("s1_done_nwr", 32'(wr_cnt - base), 32'd2);
    check_eq("s1_done_run", {31'd0, core_run}, 32'd1);

    // Scenario 2: bad checksum, trailing bytes ignored
    do_reset();
    check_eq("s2_rst_run", {31'd0, core_run}, 32'd0);
    base = wr_cnt;
    send_s1(8'h2B);
    check_eq("s2_nwr",  32'(wr_cnt - base), 32'd2);
    check_eq("s2_d1",   wr_data[8'(base + 1)], 32'hDEADBEEF);
    check_eq("s2_err",  {31'd0, err},      32'd1);
    check_eq("s2_run",  {31'd0, core_run}, 32'd0);
    check_eq("s2_busy", {31'd0, busy},     32'd0);
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1);
    check_eq("s2_late_nwr", 32'(wr_cnt - base), 32'd2);
    check_eq("s2_late_err", {31'd0, err}, 32'd1);

    // Scenario 3: empty image
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
    check_eq("s3_run_pre",  {31'd0, core_run}, 32'd0);
    check_eq("s3_busy_pre", {31'd0, busy},     32'd1);
    send_byte(8'h00, 1'b1);
    check_eq("s3_run", {31'd0, core_run}, 32'd1);
    check_eq("s3_err", {31'd0, err},      32'd0);
    check_eq("s3_nwr", 32'(wr_cnt - base), 32'd0);

    // Scenario 4: length above MAX_WORDS
    do_reset();
    base = wr_cnt;
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check_eq("s4_err_pre", {31'd0, err}, 32'd0);
    send_byte(8'h00, 1'b1);
    check_eq("s4_err",  {31'd0, err},  32'd1);
    check_eq("s4_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) send_byte(8'h33, 1'b1);
    check_eq("s4_nwr", 32'(wr_cnt - base), 32'd0);
    check_eq("s4_run", {31'd0, core_run}, 32'd0);

    // Scenario 5: short glitch rejected, then a framing error
    do_reset();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("s5_glitch_busy", {31'd0, busy}, 32'd0);
    check_eq("s5_glitch_err",  {31'd0, err},  32'd0);
    send_byte(8'h02, 1'b0);
    check_eq("s5_ferr",     {31'd0, err},      32'd1);
    check_eq("s5_ferr_run", {31'd0, core_run}, 32'd0);

    // Scenario 6: reset mid-frame discards the partial image
    do_reset();
    base = wr_cnt;
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    check_eq("s6_busy_part", {31'd0, busy}, 32'd1);
    check_eq("s6_nwr_part",  32'(wr_cnt - base), 32'd0);
    do_reset();
    check_eq("s6_busy_rst", {31'd0, busy}, 32'd0);
    base = wr_cnt;
    send_s1(8'h2A);
    check_eq("s6_nwr", 32'(wr_cnt - base), 32'd2);
    check_eq("s6_d0",  wr_data[base[7:0]], 32'h12345678);
    check_eq("s6_a1",  wr_addr[8'(base + 1)], 32'd1);
    check_eq("s6_d1",  wr_data[8'(base + 1)], 32'hDEADBEEF);
    check_eq("s6_run", {31'd0, core_run}, 32'd1);
    check_eq("s6_err", {31'd0, err},      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
